// File: rtl/lpc_pkg.sv
// Shared definitions for the passive LPC sniffer: FSM states and nibble codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTDIR,
    ST_SIZE,
    ST_ADDR,
    ST_DATA_W,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_DATA_R,
    ST_TAR_END
  } state_t;

  // Cycle type field (CT/DIR bits 3:2).
  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  // SYNC nibble codes.
  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_READY_MORE = 4'b1001;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;

  // Memory-cycle SIZE nibble codes.
  localparam logic [3:0] SIZE_1 = 4'h0;
  localparam logic [3:0] SIZE_2 = 4'h1;
  localparam logic [3:0] SIZE_4 = 4'h3;

  // LAD value that marks the start of a cycle when LFRAME# is low.
  localparam logic [3:0] LAD_START = 4'b0000;

endpackage

// File: rtl/lpc.sv
// Passive LPC sniffer: decodes I/O and memory cycles from LAD/LFRAME# and emits one record per completed cycle.
// Latency: out_clock_enable rises one cycle after the edge that samples the completing nibble.
// Backpressure: none; the bus is only observed and every record is a single-cycle strobe.
//
// Ports:
//   lpc_clock, lpc_reset        clock and synchronous active-high reset
//   lpc_ad[3:0], lpc_frame      LAD[3:0] and LFRAME# (active low), sampled on rising edge
//   out_cyctype_dir[3:0]        CT/DIR nibble of the completed cycle
//   out_addr[31:0]              address (I/O zero-extended from 16 bits)
//   out_data[31:0]              data, byte 0 in bits 7:0, unused bytes 0
//   out_data_size[2:0]          byte count: 1, 2 or 4
//   out_clock_enable            one-cycle strobe qualifying the outputs
module lpc
  import lpc_pkg::*;
(
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [2:0]  out_data_size,
  output logic        out_clock_enable
);

  state_t      state_q,  state_d;
  logic [3:0]  ctdir_q,  ctdir_d;
  logic [2:0]  size_q,   size_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] data_q,   data_d;

  logic [3:0]  out_ctdir_q, out_ctdir_d;
  logic [31:0] out_addr_q,  out_addr_d;
  logic [31:0] out_data_q,  out_data_d;
  logic [2:0]  out_size_q,  out_size_d;
  logic        out_stb_q,   out_stb_d;

  logic        is_io;
  logic        is_write;
  logic        addr_last;
  logic        data_last;
  logic [2:0]  data_last_idx;
  logic        emit;

  assign is_io         = (ctdir_q[3:2] == CT_IO);
  assign is_write      = ctdir_q[1];
  assign addr_last     = is_io ? (cnt_q == 3'd3) : (cnt_q == 3'd7);
  // Two nibbles per byte; size_q is 1, 2 or 4 so the last index is 1, 3 or 7.
  assign data_last_idx = 3'({size_q, 1'b0} - 4'd1);
  assign data_last     = (cnt_q == data_last_idx);

  always_comb begin
    state_d = state_q;
    ctdir_d = ctdir_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    emit    = 1'b0;

    if (!lpc_frame) begin
      // LFRAME# low overrides any decode in progress: START restarts, anything else aborts.
      if (lpc_ad == LAD_START) begin
        state_d = ST_CTDIR;
        addr_d  = '0;
        data_d  = '0;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CTDIR: begin
          ctdir_d = lpc_ad;
          cnt_d   = '0;
          if (lpc_ad[3:2] == CT_IO) begin
            size_d  = 3'd1;
            state_d = ST_ADDR;
          end else if (lpc_ad[3:2] == CT_MEM) begin
            state_d = ST_SIZE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SIZE: begin
          state_d = ST_ADDR;
          case (lpc_ad)
            SIZE_1:  size_d = 3'd1;
            SIZE_2:  size_d = 3'd2;
            SIZE_4:  size_d = 3'd4;
            default: state_d = ST_IDLE;
          endcase
        end
        ST_ADDR: begin
          addr_d = {addr_q[27:0], lpc_ad};
          cnt_d  = cnt_q + 3'd1;
          if (addr_last) begin
            cnt_d   = '0;
            state_d = is_write ? ST_DATA_W : ST_TAR1;
          end
        end
        ST_DATA_W, ST_DATA_R: begin
          // Nibble k lands at bits [4k+3:4k]: low nibble first, bytes ascending.
          data_d[{cnt_q, 2'b00} +: 4] = lpc_ad;
          cnt_d = cnt_q + 3'd1;
          if (data_last) begin
            cnt_d = '0;
            if (state_q == ST_DATA_W) begin
              state_d = ST_TAR1;
            end else begin
              emit    = 1'b1;
              state_d = ST_TAR_END;
            end
          end
        end
        ST_TAR1: state_d = ST_TAR2;
        ST_TAR2: state_d = ST_SYNC;
        ST_SYNC: begin
          cnt_d = '0;
          case (lpc_ad)
            SYNC_SHORT_WAIT, SYNC_LONG_WAIT: state_d = ST_SYNC;
            SYNC_READY, SYNC_READY_MORE: begin
              if (is_write) begin
                emit    = 1'b1;
                state_d = ST_TAR_END;
              end else begin
                state_d = ST_DATA_R;
              end
            end
            // Error and unknown codes both drop the cycle silently.
            default: state_d = ST_IDLE;
          endcase
        end
        ST_TAR_END: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_ctdir_d = out_ctdir_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_size_d  = out_size_q;
    out_stb_d   = 1'b0;
    if (emit) begin
      out_ctdir_d = ctdir_q;
      out_addr_d  = addr_q;
      // data_d includes the final read nibble sampled on this edge.
      out_data_d  = data_d;
      out_size_d  = size_q;
      out_stb_d   = 1'b1;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q     <= ST_IDLE;
      ctdir_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      out_ctdir_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_size_q  <= '0;
      out_stb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctdir_q     <= ctdir_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_ctdir_q <= out_ctdir_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_size_q  <= out_size_d;
      out_stb_q   <= out_stb_d;
    end
  end

  assign out_cyctype_dir  = out_ctdir_q;
  assign out_addr         = out_addr_q;
  assign out_data         = out_data_q;
  assign out_data_size    = out_size_q;
  assign out_clock_enable = out_stb_q;

endmodule

// File: tb/tb_lpc.sv
// Testbench for lpc: table-driven LPC cycles with a scoreboard of expected records.
// Latency: checks the strobe one cycle after the completing nibble.
// Backpressure: n/a (DUT is passive).
module tb_lpc;

  logic        clk;
  logic        rst;
  logic [3:0]  lpc_ad;
  logic        lpc_frame;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [2:0]  out_data_size;
  logic        out_clock_enable;

  lpc dut (
    .lpc_clock        (clk),
    .lpc_reset        (rst),
    .lpc_ad           (lpc_ad),
    .lpc_frame        (lpc_frame),
    .out_cyctype_dir  (out_cyctype_dir),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .out_data_size    (out_data_size),
    .out_clock_enable (out_clock_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ct;
    logic [3:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    int          nstart;
    int          nwait;
    logic [3:0]  wnib;
    logic [3:0]  fsync;
    bit          abort;
    bit          emit;
    logic [2:0]  exp_size;
  } vec_t;

  typedef struct {
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_clock_enable === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ctdir", {28'd0, out_cyctype_dir}, {28'd0, e.ct});
        check("addr",  out_addr, e.addr);
        check("data",  out_data, e.data);
        check("size",  {29'd0, out_data_size}, {29'd0, e.size});
      end
    end
  end

  task automatic nib(input logic [3:0] v, input logic f);
    @(negedge clk);
    lpc_ad    = v;
    lpc_frame = f;
  endtask

  function automatic vec_t mk(input logic [3:0] ct, input logic [3:0] sz, input logic [31:0] addr,
                              input logic [31:0] data, input int nstart, input int nwait,
                              input logic [3:0] wnib, input logic [3:0] fsync, input bit abort,
                              input bit emit, input logic [2:0] exp_size);
    vec_t v;
    v.ct = ct; v.sz = sz; v.addr = addr; v.data = data; v.nstart = nstart;
    v.nwait = nwait; v.wnib = wnib; v.fsync = fsync; v.abort = abort;
    v.emit = emit; v.exp_size = exp_size;
    return v;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 8; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic send(input vec_t v);
    exp_t        e;
    int          nb;
    int          na;
    bit          io;
    bit          wr;
    bit          ready;
    logic [31:0] mask;
    io = (v.ct[3:2] == 2'b00);
    wr = v.ct[1];
    nb = (v.exp_size == 3'd0) ? 1 : int'(v.exp_size);
    na = io ? 4 : 8;
    mask = (nb == 4) ? 32'hffffffff : ((nb == 2) ? 32'h0000ffff : 32'h000000ff);
    if (v.emit) begin
      e.ct   = v.ct;
      e.addr = io ? {16'd0, v.addr[15:0]} : v.addr;
      e.data = v.data & mask;
      e.size = v.exp_size;
      sb.push_back(e);
    end
    repeat (v.nstart) nib(4'h0, 1'b0);
    nib(v.ct, 1'b1);
    if (!io) nib(v.sz, 1'b1);
    for (int i = na - 1; i >= 0; i--) nib(v.addr[4*i +: 4], 1'b1);
    if (wr) for (int i = 0; i < 2 * nb; i++) nib(v.data[4*i +: 4], 1'b1);
    nib(4'hf, 1'b1);
    nib(4'hf, 1'b1);
    repeat (v.nwait) nib(v.wnib, 1'b1);
    if (v.abort) begin
      repeat (4) nib(4'hf, 1'b0);
      nib(4'hf, 1'b1);
      repeat (3) nib(4'hf, 1'b1);
      check("abort_no_strobe", sb.size(), 0);
      return;
    end
    nib(v.fsync, 1'b1);
    ready = (v.fsync == 4'h0) || (v.fsync == 4'h9);
    if (!wr && ready) for (int i = 0; i < 2 * nb; i++) nib(v.data[4*i +: 4], 1'b1);
    nib(4'hf, 1'b1);
    check("strobe_latency", {31'd0, out_clock_enable}, {31'd0, v.emit});
    nib(4'hf, 1'b1);
    nib(4'hf, 1'b1);
    drain("drain");
  endtask

  vec_t tbl[$];

  initial begin
    rst       = 1'b1;
    lpc_ad    = 4'hf;
    lpc_frame = 1'b1;

    //            ct     sz     addr           data           st wt wn     sync   ab emit size
    tbl.push_back(mk(4'h6, 4'h1, 32'h12347fe5, 32'h000069ce, 1, 0, 4'h5, 4'h0, 0, 1, 3'd2));
    tbl.push_back(mk(4'h6, 4'h3, 32'h12347fe4, 32'h000069cd, 1, 9, 4'h5, 4'h0, 1, 0, 3'd4));
    tbl.push_back(mk(4'h6, 4'h1, 32'h12347fe5, 32'h000069ce, 1, 0, 4'h5, 4'h0, 0, 1, 3'd2));
    tbl.push_back(mk(4'h2, 4'h0, 32'h0000002e, 32'h00000055, 1, 0, 4'h5, 4'h0, 0, 1, 3'd1));
    tbl.push_back(mk(4'h4, 4'h3, 32'hfffffff0, 32'hdeadbeef, 1, 3, 4'h6, 4'h0, 0, 1, 3'd4));
    tbl.push_back(mk(4'h2, 4'h0, 32'h00000080, 32'h00000011, 1, 0, 4'h5, 4'ha, 0, 0, 3'd1));
    tbl.push_back(mk(4'h2, 4'h0, 32'h00001234, 32'h000000a5, 3, 2, 4'h5, 4'h9, 0, 1, 3'd1));
    tbl.push_back(mk(4'h4, 4'h0, 32'h89abcdef, 32'h00000077, 1, 0, 4'h5, 4'h0, 0, 1, 3'd1));
    tbl.push_back(mk(4'h0, 4'h0, 32'h0000beef, 32'h0000003c, 1, 1, 4'h6, 4'h0, 0, 1, 3'd1));
    tbl.push_back(mk(4'h6, 4'h2, 32'h00000010, 32'h00000001, 1, 0, 4'h5, 4'h0, 0, 0, 3'd0));
    tbl.push_back(mk(4'h8, 4'h0, 32'h00000010, 32'h00000001, 1, 0, 4'h5, 4'h0, 0, 0, 3'd0));
    tbl.push_back(mk(4'h2, 4'h0, 32'h00000060, 32'h00000002, 1, 0, 4'h5, 4'h3, 0, 0, 3'd1));
    tbl.push_back(mk(4'h6, 4'h3, 32'h00c0ffee, 32'h76543210, 1, 0, 4'h5, 4'h0, 0, 1, 3'd4));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctdir", {28'd0, out_cyctype_dir}, 32'd0);
    check("rst_addr",  out_addr, 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_size",  {29'd0, out_data_size}, 32'd0);
    check("rst_stb",   {31'd0, out_clock_enable}, 32'd0);

    foreach (tbl[i]) send(tbl[i]);

    // Reset in the middle of an I/O address phase: nothing emitted, outputs cleared.
    nib(4'h0, 1'b0);
    nib(4'h2, 1'b1);
    nib(4'h0, 1'b1);
    nib(4'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    lpc_ad = 4'h2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lpc_ad = 4'hf;
    @(negedge clk);
    check("mid_rst_ctdir", {28'd0, out_cyctype_dir}, 32'd0);
    check("mid_rst_addr",  out_addr, 32'd0);
    check("mid_rst_data",  out_data, 32'd0);
    check("mid_rst_size",  {29'd0, out_data_size}, 32'd0);
    check("mid_rst_stb",   {31'd0, out_clock_enable}, 32'd0);
    // Remaining nibbles of the interrupted cycle must be ignored from IDLE.
    repeat (4) nib(4'h2, 1'b1);
    check("mid_rst_no_strobe", {31'd0, out_clock_enable}, 32'd0);
    send(mk(4'h2, 4'h0, 32'h000003f8, 32'h0000005a, 1, 0, 4'h5, 4'h0, 0, 1, 3'd1));

    repeat (4) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
